// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_e     - fetch FSM state encoding (IDLE, REQ, VALID, FAULT)
//   INSTR_W           - default instruction width
//   DEFAULT_RESET_PC  - default program counter after reset
//   PC_ALIGN_MASK     - low PC bits that must be zero for a legal fetch
//   pc_misaligned()   - returns 1 when a PC has any PC_ALIGN_MASK bit set
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
  localparam logic [63:0] PC_ALIGN_MASK    = 64'h3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic pc_misaligned(input logic [63:0] pc);
    return |(pc & PC_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: bundles the two handshakes of the fetch unit.
//   Memory side  : imem_req/imem_addr (out of fetch unit), imem_ack/imem_data (in).
//   Downstream   : Instruction/InstrValid (out of fetch unit), InstrReady (in).
// Modports:
//   master - the fetch unit itself
//   slave  - the memory + downstream consumer
//
// Handshake rules:
//   imem_req/imem_ack : a request is held (req=1, addr stable) until the cycle
//     in which imem_ack=1 is sampled; ack is ignored while req=0.
//   InstrValid/InstrReady : a transfer happens on an edge where both are 1;
//     Instruction is held stable while InstrValid=1 and InstrReady=0, and
//     InstrReady is ignored while InstrValid=0.
interface instruction_fetch_unit_if #(
  parameter int INSTR_W = fetch_pkg::INSTR_W
);

  logic               imem_req;
  logic [63:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] Instruction;
  logic               InstrValid;
  logic               InstrReady;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output Instruction,
    output InstrValid,
    input  InstrReady
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  Instruction,
    input  InstrValid,
    output InstrReady
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: 64-bit program counter register.
//   clk      - clock
//   rst_n    - asynchronous active-low reset, loads RESET_PC
//   load_i   - load enable; pc_d_i is captured verbatim (no alignment or wrap logic)
//   pc_d_i   - next PC value
//   pc_q_o   - current PC
module fetch_pc_reg #(
  parameter logic [63:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] pc_d_i,
  output logic [63:0] pc_q_o
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;

  assign pc_d = load_i ? pc_d_i : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the program counter, fetches the instruction at
// CurrentPC from instruction memory and hands it downstream.
//   CLK          - clock
//   resetl       - asynchronous active-low reset
//   NextPC       - next PC from the next-PC logic, sampled only on accept
//   CurrentPC    - PC of the instruction being fetched or held
//   Fault        - sticky misaligned-PC fault (cleared only by reset)
//   FetchCount   - number of accepted instructions, wraps at 2^32
//   dbg_state_o  - current FSM state, for debug and checkers
//   bus          - memory request and downstream valid/ready handshakes
// All outputs come from registers or a decode of the state register, so no
// input reaches an output combinationally.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
  parameter int          INSTR_W  = fetch_pkg::INSTR_W
) (
  input  logic                   CLK,
  input  logic                   resetl,
  input  logic [63:0]            NextPC,
  output logic [63:0]            CurrentPC,
  output logic                   Fault,
  output logic [31:0]            FetchCount,
  output fetch_pkg::fetch_state_e dbg_state_o,
  instruction_fetch_unit_if.master bus
);

  import fetch_pkg::*;

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        fetch_count_q;
  logic [63:0]        pc_q;
  logic               accept;

  // A transfer to downstream happens only in VALID; ready elsewhere is ignored.
  assign accept = (state_q == S_VALID) && bus.InstrReady;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (CLK),
    .rst_n  (resetl),
    .load_i (accept),
    .pc_d_i (NextPC),
    .pc_q_o (pc_q)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_data;
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (bus.InstrReady) begin
            fetch_count_q <= fetch_count_q + 32'd1;
            // The PC register loads NextPC on this same edge; a misaligned
            // target is never requested from memory.
            state_q <= pc_misaligned(NextPC) ? S_FAULT : S_REQ;
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are pure state decodes, so an asynchronous reset drops
  // imem_req and InstrValid in the same instant the state returns to IDLE.
  assign bus.imem_req    = (state_q == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.InstrValid  = (state_q == S_VALID);
  assign bus.Instruction = instr_q;

  assign CurrentPC   = pc_q;
  assign Fault       = (state_q == S_FAULT);
  assign FetchCount  = fetch_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Owns the program counter and the instruction-memory request side of the datapath.
- Holds `CurrentPC`, fetches the 32-bit instruction at that address over a req/ack handshake, and presents it downstream with a valid/ready handshake.
- When downstream accepts an instruction, it loads the PC chosen by the next-PC logic.
- It is the consumer of `NextPC` and the producer of `CurrentPC`, closing the PC loop.

## Interface

Parameters:
- `RESET_PC`, default 64'h0: value loaded into `CurrentPC` on reset.
- `INSTR_W`, default 32: instruction width.

Ports:
- `CLK` input, 1: the single clock.
- `resetl` input, 1: asynchronous, active-low reset.
- `NextPC` input, 64: next PC from the next-PC logic. Sampled only at the accept edge.
- `CurrentPC` output, 64: architectural PC of the instruction being fetched or held.
- `imem_req` output, 1: instruction-memory request.
- `imem_addr` output, 64: request address; always equals `CurrentPC`.
- `imem_ack` input, 1: memory response valid. Meaningful only while `imem_req`=1.
- `imem_data` input, `INSTR_W`: instruction word, valid with `imem_ack`.
- `Instruction` output, `INSTR_W`: registered fetched instruction.
- `InstrValid` output, 1: `Instruction` is valid for `CurrentPC`.
- `InstrReady` input, 1: downstream accepts `Instruction` this cycle.
- `Fault` output, 1: sticky misaligned-PC fault.
- `FetchCount` output, 32: count of accepted instructions; wraps modulo 2^32.

## Operation

States:
- **IDLE** (reset state): no request; next edge goes to REQ.
- **REQ**: `imem_req`=1 with `imem_addr`=`CurrentPC`.
  - `imem_req` and the address stay stable until `imem_ack`.
  - On `imem_ack`=1, latch `imem_data` into `Instruction` and go to VALID.
  - `imem_ack` may arrive in the first REQ cycle.
- **VALID**: `InstrValid`=1 while `Instruction` and `CurrentPC` are held stable. When `InstrReady`=1:
  - increment `FetchCount`;
  - `CurrentPC` <= `NextPC`;
  - if `NextPC[1:0]`==2'b00, go to REQ;
  - otherwise go to FAULT.
  - While `InstrReady`=0, stay in VALID indefinitely.
- **FAULT**:
  - `Fault`=1, `imem_req`=0, `InstrValid`=0.
  - `CurrentPC` holds the misaligned address.
  - Exit only by reset.

Boundary conditions:
- `imem_ack` while not in REQ is ignored.
- `InstrReady` outside VALID is ignored.
- `NextPC` equal to `CurrentPC` (self-loop branch) refetches the same address normally.
- `CurrentPC` addition and wrap are the next-PC logic's concern. The PC register loads `NextPC` verbatim, and 64-bit wrap is permitted.
- Reset asserted mid-operation (any state):
  - go to IDLE immediately and asynchronously;
  - drop `imem_req` and `InstrValid` at once;
  - any outstanding memory response is discarded.

## Timing

Reset values:
- `CurrentPC`=`RESET_PC`, `imem_addr`=`RESET_PC`
- `imem_req`=0, `InstrValid`=0, `Fault`=0
- `Instruction`=0, `FetchCount`=0

Latencies:
- First request: `imem_req` rises on the first `CLK` edge after `resetl` deasserts.
- Ack to valid: `InstrValid` rises on the edge that samples `imem_ack`=1, so it is visible the following cycle.
- Accept to next request: `imem_req` for the new PC is asserted from the edge that samples `InstrValid`&`InstrReady`.

Throughput and output behaviour:
- Best-case throughput is one instruction per 2 cycles (REQ and VALID each at least one cycle).
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure

Shared package `fetch_pkg`:
- state enum (IDLE, REQ, VALID, FAULT)
- `INSTR_W` constant
- default `RESET_PC` constant
- constant `PC_ALIGN_MASK` = 64'h3

Sub-module:
- One sub-module, `fetch_pc_reg`: the 64-bit PC register with async active-low reset to `RESET_PC` and a load enable.
- The FSM, instruction latch and counter live in the top.

## Test plan

- **Reset and first fetch:** `RESET_PC`=64'h100, release `resetl`, `imem_ack`=1 with 32'hF84003E9 on the first REQ cycle.
  - `imem_addr`=64'h100.
  - `InstrValid`=1 one cycle later with `Instruction`=32'hF84003E9.
- **Slow memory:** hold `imem_ack`=0 for 5 cycles.
  - `imem_req` stays 1 and `imem_addr` stays stable throughout.
  - `InstrValid`=0 until the cycle after the ack.
- **Downstream stall then branch:** `InstrReady`=0 for 3 cycles, then 1 with `NextPC`=64'h80.
  - `Instruction` and `CurrentPC` are held during the stall.
  - After accept: `CurrentPC`=64'h80 and `FetchCount`=1.
- **Misaligned target:** accept with `NextPC`=64'h106.
  - `Fault`=1 and `CurrentPC`=64'h106.
  - `imem_req` stays 0 for 10 or more cycles, and ack pulses are ignored.
- **Reset mid-request:** assert `resetl`=0 while in REQ.
  - `imem_req`=0 immediately and `CurrentPC`=`RESET_PC`.
  - A late `imem_ack` produces no `InstrValid`.
- **Counter wrap:** preload via `FetchCount`=32'hFFFFFFFF (force), then one accept.
  - `FetchCount`=0.
